sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

Shares one sram-like memory port between the instruction-fetch requester (IF stage `inst_sram_*` path) and the data requester (MEM stage load/store path). One transaction is in flight at a time. Data wins over instruction by default, and a starvation counter guarantees instruction fetch progress. The block sits between the CPU core and the single external memory/AXI bridge port.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive data grants, taken while inst was waiting, after which inst is forced to win.
- `CNT_W`, default 3: starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `inst_req` / `data_req`  in  1  request valid; held with payload stable until matching `*_addr_ok`
- `inst_wr` / `data_wr`  in  1  1 = write
- `inst_size` / `data_size`  in  2  0 = byte, 1 = half, 2 = word
- `inst_addr` / `data_addr`  in  32  byte address
- `inst_wdata` / `data_wdata`  in  32  write data
- `inst_addr_ok` / `data_addr_ok`  out  1  request accepted, one-cycle pulse
- `inst_data_ok` / `data_data_ok`  out  1  transaction complete, one-cycle pulse
- `inst_rdata` / `data_rdata`  out  32  read data, valid with `*_data_ok`
- `mem_req`  out  1  shared-port request
- `mem_wr`, `mem_size`, `mem_addr`, `mem_wdata`  out  1/2/32/32  shared-port payload
- `mem_addr_ok`  in  1  shared port accepted the request
- `mem_data_ok`  in  1  shared port completed the transaction
- `mem_rdata`  in  32  shared-port read data

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - REQ: `mem_req` = 1, waiting for `mem_addr_ok`.
  - RESP: waiting for `mem_data_ok`.
- IDLE:
  - If any request is present, pick a winner and assert the winner's `*_addr_ok` combinationally in the same cycle.
  - At the clock edge, latch wr/size/addr/wdata and the owner bit, then go to REQ.
  - No request: stay in IDLE.
- Winner selection:
  - Only one request present: it wins.
  - Both present: data wins unless `starve_cnt` == STARVE_LIMIT, in which case inst wins.
- `starve_cnt` update at each grant:
  - Data granted while `inst_req` = 1: increment, saturating at STARVE_LIMIT.
  - Inst granted, or data granted with `inst_req` = 0: clear to 0.
- REQ:
  - Drive `mem_req` = 1 and the `mem_*` payload from latched registers.
  - On `mem_addr_ok`, go to RESP.
  - If `mem_addr_ok` and `mem_data_ok` arrive in the same cycle, the transaction completes and the FSM goes to IDLE.
- RESP: on `mem_data_ok`, go to IDLE.
- Completion (`mem_data_ok` in RESP, or the REQ same-cycle case):
  - Pulse the owner's `*_data_ok` combinationally for one cycle.
  - `inst_rdata` and `data_rdata` both pass `mem_rdata` through unconditionally; only `*_data_ok` qualifies them.
- Responses are ignored in these cases: `mem_data_ok` in IDLE, or `mem_data_ok` in REQ without `mem_addr_ok`. No `*_data_ok` is generated.
- Writes complete through `*_data_ok` exactly like reads; `rdata` is don't-care.
- `mem_*` payload is zero when `mem_req` = 0.

## Timing
- Reset values (`rst` = 1):
  - FSM = IDLE, `starve_cnt` = 0, latched payload = 0.
  - All `*_addr_ok`, `*_data_ok`, and `mem_req` = 0.
- Reset mid-transaction:
  - The next cycle is IDLE with `mem_req` = 0.
  - No `*_data_ok` is issued for the aborted transaction.
  - A late `mem_data_ok` is ignored.
- Grant latency: `*_addr_ok` in the same cycle as `*_req` if the FSM is in IDLE.
- `mem_req` rises in the cycle after the grant.
- Minimum transaction, with `mem_addr_ok` in the first REQ cycle and `mem_data_ok` one cycle later:
  - Grant at T0, REQ at T1, `*_data_ok` at T2, next grant no earlier than T3.
  - Peak throughput: 1 transaction per 3 cycles.
- Requests arriving while the FSM is not in IDLE wait; their `*_addr_ok` stays 0.
- A requester may change payload or drop `req` in the cycle after its `addr_ok`.

## Structure
- `lib/defines.vh` additions:
  - Arbiter state encodings `ARB_IDLE` = 2'd0, `ARB_REQ` = 2'd1, `ARB_RESP` = 2'd2.
  - Size codes `SIZE_B` / `SIZE_H` / `SIZE_W`.
  - Bus width macro for the packed request payload (wr, size, addr, wdata = 67 bits).
- Single flat module; no sub-module. Winner selection is a small combinational block inside.

## Test plan
- Single inst read: `inst_req` = 1, addr 0xbfc00000; memory gives `addr_ok` in the first REQ cycle, `data_ok` + rdata 0x3c08bfaf one cycle later.
  - Expect `inst_addr_ok` at T0, `mem_addr` = 0xbfc00000 at T1, `inst_data_ok` with rdata 0x3c08bfaf at T2.
- Simultaneous requests: inst 0xbfc00004, data write 0x80001000 word 0x12345678.
  - Data is granted first; `mem_wr` = 1, `mem_wdata` = 0x12345678.
  - Inst is granted at the next IDLE.
- Starvation: both requests held continuously with STARVE_LIMIT = 4.
  - Grant order: D, D, D, D, I, then the count restarts.
- Memory stall: `mem_addr_ok` withheld 5 cycles, then `mem_data_ok` 3 cycles after `mem_addr_ok`.
  - `mem_req` and payload stay stable throughout; exactly one `*_data_ok`.
- Boundary: `mem_addr_ok` and `mem_data_ok` asserted together in REQ.
  - Completion in that cycle, IDLE next cycle.
  - A spurious `mem_data_ok` in IDLE produces no `*_data_ok`.
- Reset in RESP: `rst` at T, then `mem_data_ok` at T+2.
  - No `*_data_ok`; `mem_req` = 0 from T+1; `starve_cnt` = 0.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// rtl/sram_bus_arbiter_pkg.sv - shared types and codes for the sram bus arbiter
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int PAYLOAD_W = 67;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic req_t pack_req(input logic wr, input logic [1:0] size,
                                      input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.wr    = wr;
        r.size  = size;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - one-in-flight arbiter sharing a memory port between inst fetch and data
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_owner_data;
    req_t             r_req;

    logic             w_inst_win;
    logic             w_data_win;
    logic             w_grant;
    logic             w_done;
    logic [PAYLOAD_W-1:0] w_win_payload;

    // Data has priority unless inst has already lost STARVE_LIMIT times in a row.
    always_comb begin
        w_inst_win    = inst_req && (!data_req || (r_starve_cnt == LIMIT));
        w_data_win    = data_req && !w_inst_win;
        w_grant       = (r_state == ARB_IDLE) && (inst_req || data_req);
        w_win_payload = w_inst_win ? pack_req(inst_wr, inst_size, inst_addr, inst_wdata)
                                   : pack_req(data_wr, data_size, data_addr, data_wdata);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        mem_req      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (inst_req || data_req) begin
                    inst_addr_ok = w_inst_win;
                    data_addr_ok = w_data_win;
                    w_state_nxt  = ARB_REQ;
                end
            end
            ARB_REQ: begin
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    w_done      = mem_data_ok;
                    w_state_nxt = mem_data_ok ? ARB_IDLE : ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (mem_data_ok) begin
                    w_done      = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
        // Reset kills handshakes in the reset cycle itself, including a late response.
        if (rst) begin
            inst_addr_ok = 1'b0;
            data_addr_ok = 1'b0;
            mem_req      = 1'b0;
            w_done       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req        <= '0;
            r_owner_data <= 1'b0;
            r_starve_cnt <= '0;
        end else if (w_grant) begin
            r_req        <= w_win_payload;
            r_owner_data <= w_data_win;
            if (w_data_win && inst_req) begin
                r_starve_cnt <= (r_starve_cnt == LIMIT) ? r_starve_cnt : r_starve_cnt + CNT_W'(1);
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    assign inst_data_ok = w_done && !r_owner_data;
    assign data_data_ok = w_done &&  r_owner_data;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign mem_wr    = mem_req ? r_req.wr    : 1'b0;
    assign mem_size  = mem_req ? r_req.size  : 2'd0;
    assign mem_addr  = mem_req ? r_req.addr  : 32'd0;
    assign mem_wdata = mem_req ? r_req.wdata : 32'd0;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed and randomized checks of sram_bus_arbiter against a transaction model
module tb_sram_bus_arbiter;
    import sram_bus_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = SIZE_W; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = SIZE_W; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
    endtask

    // Behavioural model state: one transaction in flight, described by its phase.
    logic        m_busy, m_acc, m_owner_data;
    logic [66:0] m_pay;
    int          m_cnt;
    logic        e_iw, e_dw, e_mreq, e_done, i_ack, d_ack;
    logic [5:0]  ord;
    int          sum;

    initial begin
        rst = 1;
        idle_inputs();
        tick();
        inst_req = 1; data_req = 1;
        settle();
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_payload", {mem_wr, mem_size, mem_addr, mem_wdata}, 0);
        tick();
        rst = 0;
        idle_inputs();

        // Single inst read
        inst_req = 1; inst_addr = 32'hbfc00000; inst_size = SIZE_W;
        settle();
        chk("t1_inst_addr_ok", inst_addr_ok, 1);
        chk("t1_mem_req_t0", mem_req, 0);
        tick();
        inst_req = 0; inst_addr = 32'h0; mem_addr_ok = 1;
        settle();
        chk("t1_mem_req_t1", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'hbfc00000);
        chk("t1_early_data_ok", inst_data_ok, 0);
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h3c08bfaf;
        settle();
        chk("t1_inst_data_ok", inst_data_ok, 1);
        chk("t1_inst_rdata", inst_rdata, 32'h3c08bfaf);
        chk("t1_data_data_ok", data_data_ok, 0);
        tick();
        mem_data_ok = 0;
        settle();
        chk("t1_mem_req_t3", mem_req, 0);

        // Simultaneous: data write first, inst next; inst completes with same-cycle ok
        tick();
        inst_req = 1; inst_addr = 32'hbfc00004;
        data_req = 1; data_wr = 1; data_addr = 32'h80001000; data_wdata = 32'h12345678; data_size = SIZE_W;
        settle();
        chk("t2_data_addr_ok", data_addr_ok, 1);
        chk("t2_inst_addr_ok", inst_addr_ok, 0);
        tick();
        data_req = 0; mem_addr_ok = 1;
        settle();
        chk("t2_mem_wr", mem_wr, 1);
        chk("t2_mem_wdata", mem_wdata, 32'h12345678);
        chk("t2_mem_addr", mem_addr, 32'h80001000);
        chk("t2_inst_wait", inst_addr_ok, 0);
        tick();
        mem_addr_ok = 0; mem_data_ok = 1;
        settle();
        chk("t2_data_data_ok", data_data_ok, 1);
        chk("t2_inst_wait_resp", inst_addr_ok, 0);
        tick();
        mem_data_ok = 0;
        settle();
        chk("t2_inst_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0; mem_addr_ok = 1; mem_data_ok = 1;
        settle();
        chk("t2_same_cycle_done", inst_data_ok, 1);
        chk("t2_same_cycle_mreq", mem_req, 1);
        tick();
        mem_addr_ok = 0;
        settle();
        chk("t2_spurious_inst", inst_data_ok, 0);
        chk("t2_spurious_data", data_data_ok, 0);
        chk("t2_idle_mreq", mem_req, 0);
        tick();
        mem_data_ok = 0;

        // Starvation order with both requests held and a zero-wait memory
        do_reset();
        ord = 6'b101111;
        inst_req = 1; inst_addr = 32'hbfc00100; data_req = 1; data_addr = 32'h80002000;
        mem_addr_ok = 1; mem_data_ok = 1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("starve_data_grant", data_addr_ok, ord[i]);
            chk("starve_inst_grant", inst_addr_ok, !ord[i]);
            tick();
            settle();
            chk("starve_done_owner", data_data_ok, ord[i]);
            tick();
        end

        // Reset while in RESP with the counter at its limit
        do_reset();
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
        end
        settle();
        chk("rr_fourth_data", data_addr_ok, 1);
        tick();
        mem_data_ok = 0;
        settle();
        chk("rr_req", mem_req, 1);
        tick();
        mem_addr_ok = 0; rst = 1;
        settle();
        chk("rr_rst_mreq", mem_req, 0);
        tick();
        rst = 0; inst_req = 0; data_req = 0;
        settle();
        chk("rr_t1_mreq", mem_req, 0);
        tick();
        mem_data_ok = 1;
        settle();
        chk("rr_late_data_ok", data_data_ok, 0);
        chk("rr_late_inst_ok", inst_data_ok, 0);
        tick();
        mem_data_ok = 0; inst_req = 1; data_req = 1;
        settle();
        chk("rr_cnt_cleared", data_addr_ok, 1);

        // Memory stall
        do_reset();
        inst_req = 1; inst_addr = 32'h00001000; inst_size = SIZE_H;
        settle();
        chk("st_grant", inst_addr_ok, 1);
        sum = 0;
        tick();
        inst_req = 0; inst_addr = 32'hdeadbeef;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("st_mreq_hold", mem_req, 1);
            chk("st_payload_hold", {mem_wr, mem_size, mem_addr}, {1'b0, SIZE_H, 32'h00001000});
            sum += int'(inst_data_ok);
            tick();
        end
        mem_addr_ok = 1;
        settle();
        chk("st_mreq_accept", mem_req, 1);
        sum += int'(inst_data_ok);
        for (int i = 1; i <= 4; i++) begin
            tick();
            mem_addr_ok = 0;
            mem_data_ok = (i == 3);
            settle();
            sum += int'(inst_data_ok);
        end
        chk("st_done_count", sum, 1);

        // Randomized phase against the transaction model
        do_reset();
        m_busy = 0; m_acc = 0; m_owner_data = 0; m_pay = 0; m_cnt = 0;
        i_ack = 1; d_ack = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 99) == 0);
            if (i_ack || !inst_req) begin
                inst_req = 1'($urandom_range(0, 1)); inst_wr = 1'($urandom_range(0, 1));
                inst_size = 2'($urandom_range(0, 2)); inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (d_ack || !data_req) begin
                data_req = 1'($urandom_range(0, 1)); data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2)); data_addr = $urandom; data_wdata = $urandom;
            end
            mem_addr_ok = 1'($urandom_range(0, 1));
            mem_data_ok = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            settle();
            e_iw   = !rst && !m_busy && inst_req && (!data_req || m_cnt == LIMIT);
            e_dw   = !rst && !m_busy && data_req && !e_iw;
            e_mreq = !rst && m_busy && !m_acc;
            e_done = !rst && m_busy && mem_data_ok && (m_acc || mem_addr_ok);
            chk("rnd_inst_addr_ok", inst_addr_ok, e_iw);
            chk("rnd_data_addr_ok", data_addr_ok, e_dw);
            chk("rnd_mem_req", mem_req, e_mreq);
            chk("rnd_mem_payload", {mem_wr, mem_size, mem_addr, mem_wdata}, e_mreq ? m_pay : 67'd0);
            chk("rnd_inst_data_ok", inst_data_ok, e_done && !m_owner_data);
            chk("rnd_data_data_ok", data_data_ok, e_done && m_owner_data);
            chk("rnd_inst_rdata", inst_rdata, mem_rdata);
            chk("rnd_data_rdata", data_rdata, mem_rdata);
            i_ack = e_iw;
            d_ack = e_dw;
            if (rst) begin
                m_busy = 0; m_acc = 0; m_cnt = 0;
            end else if (e_iw || e_dw) begin
                m_busy = 1; m_acc = 0; m_owner_data = e_dw;
                m_pay = e_iw ? {inst_wr, inst_size, inst_addr, inst_wdata}
                             : {data_wr, data_size, data_addr, data_wdata};
                if (e_dw && inst_req) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
                else                  m_cnt = 0;
            end else if (e_done) begin
                m_busy = 0;
            end else if (e_mreq && mem_addr_ok) begin
                m_acc = 1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
